quad_encoder_gen: RTL and testbench

Quadrature encoder emulator for the laser turret. It generates `codeA`/`codeB` quadrature and an `Opto` once-per-revolution index from a commanded step period and direction. It drives the turret decoder/laser timing path in hardware-in-the-loop tests and stands in for the physical encoder on the bench board. It also reports its own position and revolution count so software can cross-check the decoder's counts.

---
 rtl/quad_encoder_gen_pkg.sv | 41 ++++
 rtl/quad_encoder_gen_if.sv | 30 +++
 rtl/quad_encoder_gen_step_timer.sv | 48 ++++
 rtl/quad_encoder_gen.sv | 85 ++++++++
 tb/tb_quad_encoder_gen.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/quad_encoder_gen_pkg.sv
// Shared quadrature definitions for the encoder emulator and the turret decoder side.
// Latency: n/a (types, constants and a pure next-state function only).
// Backpressure: n/a.
// Contents: quad_state_t ({A,B} encoding), quad_next() sequence stepping,
//           DEFAULT_TICKS_PER_REV and the position/revolution word width.
package botassium_pkg;

    localparam int DEFAULT_TICKS_PER_REV = 1024;
    localparam int POS_W                 = 16;

    // Encoding is literally {A,B}, so the state bits drive codeA/codeB directly.
    typedef enum logic [1:0] {
        Q00 = 2'b00,
        Q10 = 2'b10,
        Q11 = 2'b11,
        Q01 = 2'b01
    } quad_state_t;

    // One position along the Gray sequence; rev=0 forward (A leads), rev=1 reverse.
    function automatic quad_state_t quad_next(input quad_state_t q, input logic rev);
        quad_state_t n;
        n = Q00;
        if (!rev) begin
            case (q)
                Q00:     n = Q10;
                Q10:     n = Q11;
                Q11:     n = Q01;
                default: n = Q00;
            endcase
        end else begin
            case (q)
                Q00:     n = Q01;
                Q01:     n = Q11;
                Q11:     n = Q10;
                default: n = Q00;
            endcase
        end
        return n;
    endfunction

endpackage

// File: rtl/quad_encoder_gen_if.sv
// Command/status bundle between the encoder emulator and whoever drives it.
// Latency: n/a (wires only).
// Backpressure: none; commands are levels, status is free-running.
// master: drives enable/period/dir, observes codeA/codeB/Opto/step/position/rev_count.
// slave : the generator, the reverse of master.
interface quad_encoder_gen_if
    import botassium_pkg::*;
#(
    parameter int DIV_W = 16
);
    logic             enable;
    logic [DIV_W-1:0] period;
    logic             dir;
    logic             codeA;
    logic             codeB;
    logic             Opto;
    logic             step;
    logic [POS_W-1:0] position;
    logic [POS_W-1:0] rev_count;

    modport master (
        output enable, period, dir,
        input  codeA, codeB, Opto, step, position, rev_count
    );

    modport slave (
        input  enable, period, dir,
        output codeA, codeB, Opto, step, position, rev_count
    );
endinterface

// File: rtl/quad_encoder_gen_step_timer.sv
// Step timer: counts clocks per quadrature state and strobes tick on the last one.
// Latency: tick is combinational in the cycle the timer sits at P-1.
// Backpressure: none; enable_i=0 or period_i=0 clears the count and suppresses tick at once.
// Ports: clk, reset_n (async, active-low), enable_i, period_i[DIV_W], tick_o.
module quad_step_timer #(
    parameter int DIV_W      = 16,
    parameter int MIN_PERIOD = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable_i,
    input  logic [DIV_W-1:0] period_i,
    output logic             tick_o
);

    localparam logic [DIV_W-1:0] MIN_P = DIV_W'(MIN_PERIOD);

    logic [DIV_W-1:0] timer_q, timer_d;
    logic [DIV_W-1:0] per_q, per_d;
    logic [DIV_W-1:0] per_clamped;
    logic             run;

    always_comb begin
        run         = enable_i && (period_i != '0);
        per_clamped = (period_i < MIN_P) ? MIN_P : period_i;
        // The period is latched on the first count of each interval and held,
        // so a change on period_i never shortens an interval already running.
        per_d       = (timer_q == '0) ? per_clamped : per_q;
        tick_o      = run && (timer_q == (per_d - DIV_W'(1)));
        timer_d     = timer_q;
        if (!run || tick_o) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_q <= '0;
            per_q   <= MIN_P;
        end else begin
            timer_q <= timer_d;
            per_q   <= per_d;
        end
    end

endmodule

// File: rtl/quad_encoder_gen.sv
// Quadrature encoder emulator: codeA/codeB, once-per-rev Opto index, position and rev count.
// Latency: outputs and step change 1 clock after the timer's terminal count.
// Backpressure: none; enable=0 or period=0 freezes all state with the timer cleared.
// Ports: clk, reset_n (async, active-low), bus (quad_encoder_gen_if.slave).
module quad_encoder_gen
    import botassium_pkg::*;
#(
    parameter int TICKS_PER_REV = DEFAULT_TICKS_PER_REV,
    parameter int DIV_W         = 16,
    parameter int MIN_PERIOD    = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    quad_encoder_gen_if.slave   bus
);

    localparam logic [POS_W-1:0] LAST_POS = POS_W'(TICKS_PER_REV - 1);

    logic             tick;
    quad_state_t      q_q;
    logic [1:0]       q_bits;
    logic             step_q;
    logic             opto_q;
    logic [POS_W-1:0] pos_q;
    logic [POS_W-1:0] rev_q;

    quad_step_timer #(
        .DIV_W      (DIV_W),
        .MIN_PERIOD (MIN_PERIOD)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable_i (bus.enable),
        .period_i (bus.period),
        .tick_o   (tick)
    );

    // Sequencer, position, revolution and index all advance on the same tick.
    // Position counts A rising edges only: 00->10 forward, 01->11 reverse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q    <= Q00;
            step_q <= 1'b0;
            opto_q <= 1'b0;
            pos_q  <= '0;
            rev_q  <= '0;
        end else begin
            step_q <= tick;
            if (tick) begin
                q_q    <= quad_next(q_q, bus.dir);
                // Index lasts exactly one state interval unless re-armed below.
                opto_q <= 1'b0;
                if (!bus.dir && (q_q == Q00)) begin
                    if (pos_q == LAST_POS) begin
                        pos_q  <= '0;
                        rev_q  <= rev_q + POS_W'(1);
                        opto_q <= 1'b1;
                    end else begin
                        pos_q <= pos_q + POS_W'(1);
                    end
                end else if (bus.dir && (q_q == Q01)) begin
                    if (pos_q == '0) begin
                        pos_q <= LAST_POS;
                        rev_q <= rev_q - POS_W'(1);
                    end else begin
                        pos_q <= pos_q - POS_W'(1);
                        // Arriving at 0 from above also marks the index.
                        if (pos_q == POS_W'(1)) begin
                            opto_q <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign q_bits        = q_q;
    assign bus.codeA     = q_bits[1];
    assign bus.codeB     = q_bits[0];
    assign bus.Opto      = opto_q;
    assign bus.step      = step_q;
    assign bus.position  = pos_q;
    assign bus.rev_count = rev_q;

endmodule

// File: tb/tb_quad_encoder_gen.sv
module tb_quad_encoder_gen;

    localparam int TPR  = 8;
    localparam int MINP = 4;

    logic clk;
    logic reset_n;
    int   tests;
    int   fails;

    quad_encoder_gen_if #(.DIV_W(16)) bus ();

    quad_encoder_gen #(
        .TICKS_PER_REV (TPR),
        .DIV_W         (16),
        .MIN_PERIOD    (MINP)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    // Position is kept as a signed total of A rising edges; position and
    // revolution are derived from it by modulo / floor division.
    int   m_elapsed;
    int   m_plen;
    int   m_phase;   // index into forward sequence 00,10,11,01
    int   m_edges;
    logic m_opto;
    logic m_step;
    logic [1:0] fwd_seq [4];

    initial begin
        fwd_seq[0] = 2'b00;
        fwd_seq[1] = 2'b10;
        fwd_seq[2] = 2'b11;
        fwd_seq[3] = 2'b01;
    end

    function automatic int pos_of(input int e);
        int r;
        r = e % TPR;
        if (r < 0) r = r + TPR;
        return r;
    endfunction

    function automatic int rev_of(input int e);
        int q;
        q = e / TPR;
        if (e < 0 && (e % TPR) != 0) q = q - 1;
        return q & 32'hFFFF;
    endfunction

    task automatic model_step(input logic d);
        int old;
        old    = m_phase;
        m_opto = 1'b0;
        if (!d) begin
            m_phase = (m_phase + 1) % 4;
            if (m_phase == 1) begin
                m_edges = m_edges + 1;
                if (pos_of(m_edges) == 0) m_opto = 1'b1;
            end
        end else begin
            m_phase = (m_phase + 3) % 4;
            if (old == 3) begin
                m_edges = m_edges - 1;
                if (pos_of(m_edges) == 0) m_opto = 1'b1;
            end
        end
    endtask

    always begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_elapsed = 0; m_plen = MINP; m_phase = 0;
            m_edges = 0;   m_opto = 1'b0; m_step = 1'b0;
        end else if (clk) begin
            m_step = 1'b0;
            if (!bus.enable || bus.period == 16'd0) begin
                m_elapsed = 0;
            end else begin
                if (m_elapsed == 0) m_plen = (int'(bus.period) < MINP) ? MINP : int'(bus.period);
                m_elapsed = m_elapsed + 1;
                if (m_elapsed == m_plen) begin
                    m_elapsed = 0;
                    m_step    = 1'b1;
                    model_step(bus.dir);
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        tests = tests + 1;
        if (act !== want) begin
            fails = fails + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_A"},    32'(bus.codeA),     32'(fwd_seq[m_phase][1]));
        chk({tag, "_B"},    32'(bus.codeB),     32'(fwd_seq[m_phase][0]));
        chk({tag, "_opto"}, 32'(bus.Opto),      32'(m_opto));
        chk({tag, "_step"}, 32'(bus.step),      32'(m_step));
        chk({tag, "_pos"},  32'(bus.position),  pos_of(m_edges));
        chk({tag, "_rev"},  32'(bus.rev_count), rev_of(m_edges));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_A"},    32'(bus.codeA),     0);
        chk({tag, "_B"},    32'(bus.codeB),     0);
        chk({tag, "_opto"}, 32'(bus.Opto),      0);
        chk({tag, "_step"}, 32'(bus.step),      0);
        chk({tag, "_pos"},  32'(bus.position),  0);
        chk({tag, "_rev"},  32'(bus.rev_count), 0);
    endtask

    task automatic drive(input logic en, input logic [15:0] per, input logic d);
        bus.enable = en;
        bus.period = per;
        bus.dir    = d;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(1'b0, 16'd0, 1'b0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    typedef struct {
        logic        en;
        logic [15:0] per;
        logic        d;
        int          n;
        logic        a, b, op, st;
        logic [15:0] pos, rev;
    } vec_t;

    vec_t vecs [16];

    initial begin
        int opto_cnt;
        tests = 0;
        fails = 0;
        reset_n = 1'b1;
        drive(1'b0, 16'd0, 1'b0);

        //          en    per    dir   n   A     B     opto  step  pos    rev
        vecs[0]  = '{1'b1, 16'd4, 1'b0, 4, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1, 16'd0};
        vecs[1]  = '{1'b1, 16'd4, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1, 16'd0};
        vecs[2]  = '{1'b1, 16'd4, 1'b0, 3, 1'b1, 1'b1, 1'b0, 1'b1, 16'd1, 16'd0};
        vecs[3]  = '{1'b1, 16'd4, 1'b0, 4, 1'b0, 1'b1, 1'b0, 1'b1, 16'd1, 16'd0};
        vecs[4]  = '{1'b1, 16'd4, 1'b0, 4, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 16'd0};
        vecs[5]  = '{1'b1, 16'd4, 1'b0, 4, 1'b1, 1'b0, 1'b0, 1'b1, 16'd2, 16'd0};
        vecs[6]  = '{1'b1, 16'd4, 1'b1, 4, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2, 16'd0};
        vecs[7]  = '{1'b1, 16'd4, 1'b1, 4, 1'b0, 1'b1, 1'b0, 1'b1, 16'd2, 16'd0};
        vecs[8]  = '{1'b1, 16'd4, 1'b1, 4, 1'b1, 1'b1, 1'b0, 1'b1, 16'd1, 16'd0};
        vecs[9]  = '{1'b0, 16'd4, 1'b1, 10, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1, 16'd0};
        vecs[10] = '{1'b1, 16'd6, 1'b1, 5, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1, 16'd0};
        vecs[11] = '{1'b1, 16'd6, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1, 16'd0};
        vecs[12] = '{1'b1, 16'd2, 1'b1, 4, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 16'd0};
        vecs[13] = '{1'b1, 16'd1, 1'b1, 4, 1'b0, 1'b1, 1'b0, 1'b1, 16'd1, 16'd0};
        vecs[14] = '{1'b1, 16'd4, 1'b1, 4, 1'b1, 1'b1, 1'b1, 1'b1, 16'd0, 16'd0};
        vecs[15] = '{1'b1, 16'd4, 1'b1, 4, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0, 16'd0};

        // Reset state
        do_reset();
        check_zero("reset");

        // Table-driven directed run from reset
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].en, vecs[i].per, vecs[i].d);
            repeat (vecs[i].n) @(negedge clk);
            chk($sformatf("vec%0d_A", i),    32'(bus.codeA),     32'(vecs[i].a));
            chk($sformatf("vec%0d_B", i),    32'(bus.codeB),     32'(vecs[i].b));
            chk($sformatf("vec%0d_opto", i), 32'(bus.Opto),      32'(vecs[i].op));
            chk($sformatf("vec%0d_step", i), 32'(bus.step),      32'(vecs[i].st));
            chk($sformatf("vec%0d_pos", i),  32'(bus.position),  32'(vecs[i].pos));
            chk($sformatf("vec%0d_rev", i),  32'(bus.rev_count), 32'(vecs[i].rev));
        end

        // Forward wrap 7->0: edge 8 lands on step 29 = 116 clocks
        do_reset();
        drive(1'b1, 16'd4, 1'b0);
        repeat (115) @(negedge clk);
        chk("wrap_pre_pos",  32'(bus.position), 7);
        chk("wrap_pre_opto", 32'(bus.Opto),     0);
        @(negedge clk);
        chk("wrap_pos",  32'(bus.position),  0);
        chk("wrap_rev",  32'(bus.rev_count), 1);
        chk("wrap_opto", 32'(bus.Opto),      1);
        opto_cnt = 1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (bus.Opto) opto_cnt = opto_cnt + 1;
        end
        chk("wrap_opto_width", opto_cnt, 4);

        // Reverse from 0: 00->01, then 01->11 takes position to 7
        do_reset();
        drive(1'b1, 16'd4, 1'b1);
        repeat (4) @(negedge clk);
        chk("rev0_first_pos", 32'(bus.position), 0);
        chk("rev0_first_B",   32'(bus.codeB),    1);
        repeat (4) @(negedge clk);
        chk("rev0_pos",  32'(bus.position),  7);
        chk("rev0_rev",  32'(bus.rev_count), 32'hFFFF);
        chk("rev0_opto", 32'(bus.Opto),      0);

        // period=0 freezes; restoring period=6 waits a full 6 clocks
        do_reset();
        drive(1'b1, 16'd4, 1'b0);
        repeat (6) @(negedge clk);
        drive(1'b1, 16'd0, 1'b0);
        repeat (10) @(negedge clk);
        chk("stop_A",    32'(bus.codeA), 1);
        chk("stop_B",    32'(bus.codeB), 0);
        chk("stop_step", 32'(bus.step),  0);
        drive(1'b1, 16'd6, 1'b0);
        repeat (5) @(negedge clk);
        chk("restart_early_B",    32'(bus.codeB), 0);
        chk("restart_early_step", 32'(bus.step),  0);
        @(negedge clk);
        chk("restart_B",    32'(bus.codeB), 1);
        chk("restart_step", 32'(bus.step),  1);

        // Asynchronous reset mid-revolution at position 5
        do_reset();
        drive(1'b1, 16'd4, 1'b0);
        repeat (70) @(negedge clk);
        chk("midrst_pre_pos", 32'(bus.position), 5);
        #2 reset_n = 1'b0;
        #1 check_zero("midrst");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("midrst_resume_pos",  32'(bus.position), 1);
        chk("midrst_resume_A",    32'(bus.codeA),    1);
        chk("midrst_resume_opto", 32'(bus.Opto),     0);

        // Randomized run against the reference model
        do_reset();
        drive(1'b1, 16'd4, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            check_model("rnd");
            if (i == 1500) reset_n = 1'b0;
            if (i == 1503) reset_n = 1'b1;
            bus.enable = ($urandom_range(0, 29) != 0);
            if ($urandom_range(0, 49) == 0) bus.period = 16'($urandom_range(0, 9));
            if ($urandom_range(0, 24) == 0) bus.dir = ~bus.dir;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
